// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer and the data memory: funct3 size codes,
// memory-port ownership and a store-code classifier.
package store_buffer_pkg;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    PORT_IDLE,
    PORT_LOAD,
    PORT_DRAIN
  } port_sel_e;

  // Only byte, half and word stores are buffered; any other code is dropped.
  function automatic logic is_store_f3(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

endpackage

// File: rtl/store_buffer_sb_match.sv
// DEPTH-way word-address comparator: flags a load whose word matches any live entry.
module sb_match #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]    valid_i,
  input  logic [DEPTH*30-1:0] word_addr_i,
  input  logic [29:0]         ld_word_i,
  output logic                hit_o
);

  logic [DEPTH-1:0] hit_vec;

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_vec[i] = valid_i[i] && (word_addr_i[i*30 +: 30] == ld_word_i);
    end
  end

  assign hit_o = |hit_vec;

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer between the MEM stage and data memory; loads take priority
// over draining unless they hit a buffered word or a fence is pending.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_fund3,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_fund3,
  output logic        ld_stall,
  input  logic        fence,
  output logic        empty,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [2:0]  dm_fund3,
  output logic        dm_we
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [31:0]      addr_q  [DEPTH];
  logic [31:0]      data_q  [DEPTH];
  logic [2:0]       fund3_q [DEPTH];

  logic [DEPTH*30-1:0] word_addr_flat;
  logic                ld_conflict;
  logic                enq;
  logic                drain;
  port_sel_e           port_sel;

  always_comb begin
    word_addr_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      word_addr_flat[i*30 +: 30] = addr_q[i][31:2];
    end
  end

  sb_match #(
    .DEPTH(DEPTH)
  ) u_match (
    .valid_i    (valid_q),
    .word_addr_i(word_addr_flat),
    .ld_word_i  (ld_addr[31:2]),
    .hit_o      (ld_conflict)
  );

  assign st_ready = (count_q != FULL);
  assign empty    = (count_q == '0);
  assign ld_stall = ld_valid && (ld_conflict || (fence && !empty));
  assign enq      = st_valid && st_ready && is_store_f3(st_fund3);

  // A stalled load does not own the port, so its blocking entries keep draining.
  always_comb begin
    port_sel = PORT_IDLE;
    if (rst_n && ld_valid && !ld_stall) begin
      port_sel = PORT_LOAD;
    end else if (!empty) begin
      port_sel = PORT_DRAIN;
    end
  end

  assign drain = (port_sel == PORT_DRAIN);

  always_comb begin
    dm_addr  = '0;
    dm_wdata = '0;
    dm_fund3 = '0;
    dm_we    = 1'b0;
    case (port_sel)
      PORT_LOAD: begin
        dm_addr  = ld_addr;
        dm_fund3 = ld_fund3;
      end
      PORT_DRAIN: begin
        dm_addr  = addr_q[rptr_q];
        dm_wdata = data_q[rptr_q];
        dm_fund3 = fund3_q[rptr_q];
        dm_we    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    valid_d = valid_q;
    if (enq) begin
      wptr_d          = wptr_q + PW'(1);
      valid_d[wptr_q] = 1'b1;
    end
    if (drain) begin
      rptr_d          = rptr_q + PW'(1);
      valid_d[rptr_q] = 1'b0;
    end
    if (enq && !drain) begin
      count_d = count_q + CW'(1);
    end else if (drain && !enq) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
        fund3_q[i] <= '0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
      if (enq) begin
        addr_q[wptr_q]  <= st_addr;
        data_q[wptr_q]  <= st_data;
        fund3_q[wptr_q] <= st_fund3;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed scoreboard bench for store_buffer: expected memory-port transactions are
// queued by the stimulus and popped by a monitor whenever the DUT uses the port.
module tb_store_buffer;
  import store_buffer_pkg::*;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
  } port_txn_t;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_fund3;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [2:0]  ld_fund3;
  logic        ld_stall;
  logic        fence;
  logic        empty;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [2:0]  dm_fund3;
  logic        dm_we;

  port_txn_t expQ[$];
  int tests = 0;
  int fails = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .st_valid(st_valid),
    .st_addr (st_addr),
    .st_data (st_data),
    .st_fund3(st_fund3),
    .st_ready(st_ready),
    .ld_valid(ld_valid),
    .ld_addr (ld_addr),
    .ld_fund3(ld_fund3),
    .ld_stall(ld_stall),
    .fence   (fence),
    .empty   (empty),
    .dm_addr (dm_addr),
    .dm_wdata(dm_wdata),
    .dm_fund3(dm_fund3),
    .dm_we   (dm_we)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic stV, input logic [31:0] stA, input logic [31:0] stD,
                               input logic [2:0] stF, input logic ldV, input logic [31:0] ldA,
                               input logic [2:0] ldF, input logic fenceV);
    st_valid = stV;
    st_addr  = stA;
    st_data  = stD;
    st_fund3 = stF;
    ld_valid = ldV;
    ld_addr  = ldA;
    ld_fund3 = ldF;
    fence    = fenceV;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 32'h0, 3'b000, 1'b0);
  endtask

  task automatic expectStore(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    port_txn_t t;
    t.we = 1'b1; t.addr = a; t.data = d; t.f3 = f;
    expQ.push_back(t);
  endtask

  task automatic expectLoad(input logic [31:0] a, input logic [2:0] f);
    port_txn_t t;
    t.we = 1'b0; t.addr = a; t.data = 32'h0; t.f3 = f;
    expQ.push_back(t);
  endtask

  task automatic waitDrive();
    @(posedge clk);
    #1;
  endtask

  task automatic waitSample();
    @(negedge clk);
  endtask

  // Monitor: every cycle the port is in use, the oldest expected transaction must match.
  always @(negedge clk) begin
    if (rst_n && (dm_we || (ld_valid && !ld_stall))) begin
      if (expQ.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL port_unexpected: got we=%0b addr=0x%08h data=0x%08h, expected no port use",
                 dm_we, dm_addr, dm_wdata);
      end else begin
        port_txn_t e;
        e = expQ.pop_front();
        checkOutput("port_we", {31'h0, dm_we}, {31'h0, e.we});
        checkOutput("port_addr", dm_addr, e.addr);
        checkOutput("port_fund3", {29'h0, dm_fund3}, {29'h0, e.f3});
        if (e.we) checkOutput("port_wdata", dm_wdata, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    applyIdle();
    #3;
    checkOutput("rst_st_ready", {31'h0, st_ready}, 32'h1);
    checkOutput("rst_empty", {31'h0, empty}, 32'h1);
    checkOutput("rst_ld_stall", {31'h0, ld_stall}, 32'h0);
    checkOutput("rst_dm_we", {31'h0, dm_we}, 32'h0);
    checkOutput("rst_dm_addr", dm_addr, 32'h0);
    checkOutput("rst_dm_wdata", dm_wdata, 32'h0);
    checkOutput("rst_dm_fund3", {29'h0, dm_fund3}, 32'h0);

    // Release and store on the same cycle: enqueue happens on the first live edge.
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, F3_SW, 1'b0, 32'h0, F3_LW, 1'b0);
    expectStore(32'h10, 32'hDEADBEEF, F3_SW);
    waitDrive(); applyIdle();
    waitSample();
    checkOutput("single_we", {31'h0, dm_we}, 32'h1);
    checkOutput("single_empty_busy", {31'h0, empty}, 32'h0);
    waitDrive();
    waitSample();
    checkOutput("single_empty_done", {31'h0, empty}, 32'h1);

    // Unsupported store size is accepted and dropped.
    waitDrive(); applyStimulus(1'b1, 32'h14, 32'h77, 3'b011, 1'b0, 32'h0, F3_LW, 1'b0);
    waitSample();
    checkOutput("bad_f3_ready", {31'h0, st_ready}, 32'h1);
    waitDrive(); applyIdle();
    waitSample();
    checkOutput("bad_f3_empty", {31'h0, empty}, 32'h1);
    checkOutput("bad_f3_we", {31'h0, dm_we}, 32'h0);

    // Fill while a non-conflicting load owns the port.
    for (int i = 0; i < 4; i++) begin
      waitDrive();
      applyStimulus(1'b1, 32'(i), 32'h1111_1100 | 32'(i), F3_SB, 1'b1, 32'h100, F3_LW, 1'b0);
      expectLoad(32'h100, F3_LW);
      waitSample();
      checkOutput("fill_ready", {31'h0, st_ready}, 32'h1);
    end
    waitDrive();
    applyStimulus(1'b1, 32'h50, 32'h0BAD, F3_SW, 1'b1, 32'h100, F3_LW, 1'b0);
    expectLoad(32'h100, F3_LW);
    waitSample();
    checkOutput("full_ready", {31'h0, st_ready}, 32'h0);
    checkOutput("full_we", {31'h0, dm_we}, 32'h0);
    checkOutput("full_empty", {31'h0, empty}, 32'h0);
    waitDrive(); applyIdle();
    for (int i = 0; i < 4; i++) expectStore(32'(i), 32'h1111_1100 | 32'(i), F3_SB);
    waitSample();
    checkOutput("fill_drain_addr", dm_addr, 32'h0);
    for (int k = 1; k < 4; k++) begin
      waitDrive();
      waitSample();
      checkOutput("fill_drain_addr", dm_addr, 32'(k));
    end
    waitDrive();
    waitSample();
    checkOutput("fill_drained_empty", {31'h0, empty}, 32'h1);

    // Conflicting load stalls until its word drains.
    waitDrive(); applyStimulus(1'b1, 32'h22, 32'h0000BEEF, F3_SH, 1'b0, 32'h0, F3_LW, 1'b0);
    expectStore(32'h22, 32'h0000BEEF, F3_SH);
    waitSample();
    waitDrive(); applyStimulus(1'b0, 32'h0, 32'h0, F3_SB, 1'b1, 32'h20, F3_LW, 1'b0);
    waitSample();
    checkOutput("conflict_stall", {31'h0, ld_stall}, 32'h1);
    checkOutput("conflict_drain_we", {31'h0, dm_we}, 32'h1);
    waitDrive();
    expectLoad(32'h20, F3_LW);
    waitSample();
    checkOutput("conflict_release", {31'h0, ld_stall}, 32'h0);
    checkOutput("conflict_load_we", {31'h0, dm_we}, 32'h0);
    checkOutput("conflict_load_addr", dm_addr, 32'h20);

    // Same-cycle store and load to one word: load sees pre-store memory.
    waitDrive(); applyStimulus(1'b1, 32'h30, 32'hCAFEF00D, F3_SW, 1'b1, 32'h30, F3_LW, 1'b0);
    expectLoad(32'h30, F3_LW);
    expectStore(32'h30, 32'hCAFEF00D, F3_SW);
    waitSample();
    checkOutput("same_cycle_stall", {31'h0, ld_stall}, 32'h0);
    waitDrive(); applyIdle();
    waitSample();
    checkOutput("same_cycle_drain", {31'h0, dm_we}, 32'h1);

    // Non-conflicting load takes the port ahead of a pending drain.
    waitDrive(); applyStimulus(1'b1, 32'h40, 32'h12345678, F3_SW, 1'b0, 32'h0, F3_LW, 1'b0);
    waitSample();
    waitDrive(); applyStimulus(1'b0, 32'h0, 32'h0, F3_SB, 1'b1, 32'h80, F3_LW, 1'b0);
    expectLoad(32'h80, F3_LW);
    expectStore(32'h40, 32'h12345678, F3_SW);
    waitSample();
    checkOutput("prio_load_we", {31'h0, dm_we}, 32'h0);
    checkOutput("prio_load_addr", dm_addr, 32'h80);
    waitDrive(); applyIdle();
    waitSample();
    checkOutput("prio_drain_we", {31'h0, dm_we}, 32'h1);
    checkOutput("prio_drain_addr", dm_addr, 32'h40);

    // Fence holds an unrelated load until the buffer is empty, stores still accepted.
    waitDrive(); applyStimulus(1'b1, 32'h500, 32'h55AA55AA, F3_SW, 1'b0, 32'h0, F3_LW, 1'b1);
    expectStore(32'h500, 32'h55AA55AA, F3_SW);
    waitSample();
    checkOutput("fence_st_ready", {31'h0, st_ready}, 32'h1);
    waitDrive(); applyStimulus(1'b0, 32'h0, 32'h0, F3_SB, 1'b1, 32'h600, F3_LW, 1'b1);
    waitSample();
    checkOutput("fence_stall", {31'h0, ld_stall}, 32'h1);
    waitDrive();
    expectLoad(32'h600, F3_LW);
    waitSample();
    checkOutput("fence_release", {31'h0, ld_stall}, 32'h0);
    checkOutput("fence_empty", {31'h0, empty}, 32'h1);

    // Build count=2, then enqueue and drain together for 10 cycles across pointer wraps.
    waitDrive(); applyStimulus(1'b1, 32'h300, 32'h3000_0000, F3_SW, 1'b1, 32'h200, F3_LW, 1'b0);
    expectLoad(32'h200, F3_LW);
    waitSample();
    waitDrive(); applyStimulus(1'b1, 32'h304, 32'h3000_0001, F3_SW, 1'b1, 32'h200, F3_LW, 1'b0);
    expectLoad(32'h200, F3_LW);
    expectStore(32'h300, 32'h3000_0000, F3_SW);
    expectStore(32'h304, 32'h3000_0001, F3_SW);
    waitSample();
    for (int k = 2; k < 12; k++) begin
      waitDrive();
      applyStimulus(1'b1, 32'h300 + 32'(4*k), 32'h3000_0000 + 32'(k), F3_SW, 1'b0, 32'h0, F3_LW, 1'b0);
      expectStore(32'h300 + 32'(4*k), 32'h3000_0000 + 32'(k), F3_SW);
      waitSample();
      checkOutput("steady_empty", {31'h0, empty}, 32'h0);
      checkOutput("steady_ready", {31'h0, st_ready}, 32'h1);
    end
    waitDrive(); applyIdle();
    waitSample();
    waitDrive();
    waitSample();
    checkOutput("steady_last_busy", {31'h0, empty}, 32'h0);
    waitDrive();
    waitSample();
    checkOutput("steady_final_empty", {31'h0, empty}, 32'h1);

    // Reset while draining with three entries buffered drops the rest.
    waitDrive(); applyStimulus(1'b1, 32'h900, 32'h9, F3_SW, 1'b1, 32'h700, F3_LW, 1'b0);
    expectLoad(32'h700, F3_LW);
    waitSample();
    waitDrive(); applyStimulus(1'b1, 32'h904, 32'hA, F3_SW, 1'b1, 32'h700, F3_LW, 1'b0);
    expectLoad(32'h700, F3_LW);
    waitSample();
    waitDrive(); applyStimulus(1'b1, 32'h908, 32'hB, F3_SW, 1'b1, 32'h700, F3_LW, 1'b0);
    expectLoad(32'h700, F3_LW);
    expectStore(32'h900, 32'h9, F3_SW);
    waitSample();
    waitDrive(); applyIdle();
    waitSample();
    checkOutput("mid_drain_we", {31'h0, dm_we}, 32'h1);
    checkOutput("mid_drain_addr", dm_addr, 32'h900);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_empty", {31'h0, empty}, 32'h1);
    checkOutput("mid_rst_we", {31'h0, dm_we}, 32'h0);
    checkOutput("mid_rst_addr", dm_addr, 32'h0);
    checkOutput("mid_rst_ready", {31'h0, st_ready}, 32'h1);
    waitDrive();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      waitSample();
      checkOutput("post_rst_we", {31'h0, dm_we}, 32'h0);
      checkOutput("post_rst_empty", {31'h0, empty}, 32'h1);
      waitDrive();
    end

    checkOutput("queue_drained", 32'(expQ.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of 2, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port st_valid  input  1  MEM-stage store request.
REQ-005 SHALL have port st_addr  input  32  store byte address.
REQ-006 SHALL have port st_data  input  32  store data, bytes taken from LSBs.
REQ-007 SHALL have port st_fund3  input  3  store size (000 SB, 001 SH, 010 SW).
REQ-008 SHALL have port st_ready  output  1  buffer can accept a store this cycle.
REQ-009 SHALL have port ld_valid  input  1  MEM-stage load request.
REQ-010 SHALL have port ld_addr  input  32  load byte address.
REQ-011 SHALL have port ld_fund3  input  3  load size/sign code, passed to memory.
REQ-012 SHALL have port ld_stall  output  1  load must wait; pipeline holds MEM stage.
REQ-013 SHALL have port fence  input  1  level request to drain all stores.
REQ-014 SHALL have port empty  output  1  no stores buffered.
REQ-015 SHALL have ports dm_addr (output, 32), dm_wdata (output, 32), dm_fund3 (output, 3) and dm_we (output, 1), which drive the data-memory address, write data, fund3 and write enable.

Function
REQ-016 SHALL hold stores in a circular FIFO of DEPTH entries {addr, data, fund3} with write pointer, read pointer and count 0..DEPTH.
REQ-017 SHALL drive st_ready = (count != DEPTH), registered state only, with no same-cycle bypass when full.
REQ-018 SHALL enqueue the store at the rising edge when st_valid && st_ready && st_fund3 in {000, 001, 010}.
REQ-019 SHALL accept a store with any other st_fund3 when st_valid && st_ready and discard it without enqueueing it.
REQ-020 SHALL assert ld_stall when ld_valid and any valid entry has addr[31:2] == ld_addr[31:2] (word-granular, conservative), or when fence is high and count != 0.
REQ-021 SHALL grant the memory port for a load when ld_valid && !ld_stall, driving dm_addr = ld_addr, dm_fund3 = ld_fund3 and dm_we = 0, with no drain that cycle.
REQ-022 SHALL otherwise drain when count != 0, driving the head entry on dm_addr, dm_wdata and dm_fund3, driving dm_we = 1, and advancing the read pointer at the edge.
REQ-023 SHALL drive dm_we = 0 and hold dm_addr, dm_wdata and dm_fund3 at zero when idle.
REQ-024 SHALL drain a stalled load's blocking entries, since a stalled load does not own the port; the load SHALL proceed in the cycle after the last conflicting entry retires.
REQ-025 SHALL make the earliest drain of an entry the cycle after it is enqueued, giving enqueue-to-dm_we latency of 1 cycle.
REQ-026 SHALL update count by +1 on enqueue only, -1 on drain only, and leave it unchanged on both; enqueue and drain in one cycle SHALL be legal at any count below DEPTH.
REQ-027 SHALL wrap the pointers modulo DEPTH.
REQ-028 SHALL drain entries in FIFO order, never merging or reordering them.
REQ-029 SHALL drive empty = (count == 0).
REQ-030 SHALL keep accepting stores while fence is high, with fence completion defined as empty high.
REQ-031 SHALL not check the enqueue-time conflict against the store being enqueued in the same cycle; a load and a store to the same word in one cycle SHALL see pre-store memory.

Reset
REQ-032 SHALL, on rst_n low, immediately clear the pointers and count, all entries' valid flags and the data fields to zero.
REQ-033 SHALL hold st_ready = 1, empty = 1, ld_stall = 0 (when ld_valid is low), dm_we = 0 and dm_addr, dm_wdata and dm_fund3 at zero while rst_n is low.
REQ-034 SHALL drop buffered stores that have not drained when reset is asserted mid-operation.
REQ-035 SHALL release reset synchronously with respect to clk, with the first enqueue possible on the first edge with rst_n high.

Structure
REQ-036 SHALL place the fund3 store/load codes (SB, SH, SW, LB, LH, LW, LBU, LHU) as named constants in a shared package used by this block and the data memory.
REQ-037 SHALL contain one natural sub-module, sb_match, the combinational DEPTH-way word-address comparator producing ld_stall's conflict term.

Verification
REQ-038 SHALL cover reset and single store: store SW 0x10 <- 0xDEADBEEF, no load -> next cycle dm_we=1, dm_addr=0x10, dm_wdata=0xDEADBEEF, dm_fund3=010, then empty=1.
REQ-039 SHALL cover filling the buffer: 4 SB stores to 0x0..0x3 while ld_valid=1 to 0x100 -> st_ready=0 after the 4th, count stays 4, no dm_we; drop ld_valid -> 4 drains in order over 4 cycles.
REQ-040 SHALL cover load conflict: buffer SH 0x22 <- 0xBEEF, then load LW 0x20 -> ld_stall=1 for 1 cycle, store drains, next cycle dm_addr=0x20, dm_we=0, ld_stall=0.
REQ-041 SHALL cover no-conflict priority: buffer SW 0x40, then load LW 0x80 -> load owns the port that cycle, drain occurs the following cycle.
REQ-042 SHALL cover simultaneous enqueue and drain at count=2 -> count remains 2; the pointers wrap correctly after 10 such cycles with DEPTH=4.
REQ-043 SHALL cover reset mid-drain: count=3, rst_n low -> empty=1, dm_we=0 immediately, no further writes after release.
